// File: rtl/grostl_pkg.sv
// Shared types and constants for the serial masked Groestl compression sequencer.
// Output decode lives here so every state's control word is defined in one place.
package grostl_pkg;

    localparam int GROSTL512_ROUNDS = 14;

    localparam logic [1:0] SEL_M_LOAD  = 2'b00;
    localparam logic [1:0] SEL_M_ROUND = 2'b01;
    localparam logic [1:0] SEL_M_XOR   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XOR,
        ST_PRND,
        ST_FOLDP,
        ST_RELOAD,
        ST_QRND,
        ST_FOLDQ,
        ST_OUT,
        ST_DONE
    } grostl_ctrl_state_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       wr_m;
        logic       wr_h;
        logic [1:0] sel_m;
        logic       sel_h;
        logic       sel_pq;
        logic [3:0] round;
    } grostl_ctrl_out_t;

    localparam grostl_ctrl_out_t CTRL_OUT_IDLE = '{
        busy: 1'b0, done: 1'b0, wr_m: 1'b0, wr_h: 1'b0,
        sel_m: SEL_M_XOR, sel_h: 1'b1, sel_pq: 1'b0, round: 4'd0
    };

    // SEL_M_LOAD only ever appears in LOAD/RELOAD: the datapath relatches masks on it.
    function automatic grostl_ctrl_out_t grostl_decode(input grostl_ctrl_state_t st,
                                                       input logic [3:0]         r,
                                                       input logic               ph,
                                                       input logic               first);
        grostl_ctrl_out_t o;
        o      = CTRL_OUT_IDLE;
        o.busy = (st != ST_IDLE);
        case (st)
            ST_LOAD: begin
                o.sel_m = SEL_M_LOAD;
                o.wr_m  = 1'b1;
                o.sel_h = 1'b0;
                o.wr_h  = first;
            end
            ST_XOR, ST_OUT: begin
                o.sel_m = SEL_M_XOR;
                o.wr_m  = 1'b1;
            end
            ST_PRND, ST_QRND: begin
                o.sel_pq = (st == ST_QRND);
                o.round  = r;
                if (ph) begin
                    o.sel_m = SEL_M_ROUND;
                    o.wr_m  = 1'b1;
                end
            end
            ST_FOLDP, ST_FOLDQ: begin
                o.sel_h = 1'b1;
                o.wr_h  = 1'b1;
            end
            ST_RELOAD: begin
                o.sel_m = SEL_M_LOAD;
                o.wr_m  = 1'b1;
            end
            ST_DONE: o.done = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/grostl_round_cnt.sv
// Round index and half-round flag for one permutation pass.
// Each round spends two cycles (ph=0 then ph=1); the counter self-clears after the last one.
module grostl_round_cnt
    import grostl_pkg::*;
#(
    parameter int ROUNDS = GROSTL512_ROUNDS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       adv,
    output logic [3:0] r_q,
    output logic       ph_q,
    output logic [3:0] r_d,
    output logic       ph_d,
    output logic       last
);

    assign last = ph_q && (r_q == 4'(ROUNDS - 1));

    always_comb begin
        r_d  = r_q;
        ph_d = ph_q;
        if (clr) begin
            r_d  = 4'd0;
            ph_d = 1'b0;
        end else if (adv) begin
            if (!ph_q) begin
                ph_d = 1'b1;
            end else if (last) begin
                r_d  = 4'd0;
                ph_d = 1'b0;
            end else begin
                r_d  = r_q + 4'd1;
                ph_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q  <= 4'd0;
            ph_q <= 1'b0;
        end else begin
            r_q  <= r_d;
            ph_q <= ph_d;
        end
    end

endmodule

// File: rtl/grostl_ctrl_serial_m.sv
// Sequencer for the masked serial Groestl compression datapath (compress or output transform).
// Host handshake: start is accepted only in IDLE; busy covers LOAD..DONE; done pulses once when the result is valid.
module grostl_ctrl_serial_m
    import grostl_pkg::*;
#(
    parameter int ROUNDS = GROSTL512_ROUNDS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               first,
    input  logic               final_blk,
    output logic               busy,
    output logic               done,
    output logic               wr_m,
    output logic               wr_h,
    output logic [1:0]         sel_m,
    output logic               sel_h,
    output logic               sel_pq,
    output logic [3:0]         round,
    output grostl_ctrl_state_t dbg_state
);

    grostl_ctrl_state_t state_q, state_d;
    logic               first_q, first_d;
    logic               final_q, final_d;
    grostl_ctrl_out_t   out_q, out_d;

    logic [3:0] r_q, r_d;
    logic       ph_q, ph_d;
    logic       cnt_last;
    logic       cnt_clr, cnt_adv;

    assign cnt_clr = (state_q == ST_IDLE);
    assign cnt_adv = (state_q == ST_PRND) || (state_q == ST_QRND);

    grostl_round_cnt #(.ROUNDS(ROUNDS)) u_round_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .adv   (cnt_adv),
        .r_q   (r_q),
        .ph_q  (ph_q),
        .r_d   (r_d),
        .ph_d  (ph_d),
        .last  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        final_d = final_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_LOAD;
                first_d = first;
                final_d = final_blk;
            end
            ST_LOAD:   state_d = ST_XOR;
            ST_XOR:    state_d = ST_PRND;
            ST_PRND:   if (cnt_last) state_d = final_q ? ST_OUT : ST_FOLDP;
            ST_FOLDP:  state_d = ST_RELOAD;
            ST_RELOAD: state_d = ST_QRND;
            ST_QRND:   if (cnt_last) state_d = ST_FOLDQ;
            ST_FOLDQ:  state_d = ST_DONE;
            ST_OUT:    state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        // Decode against next state/counter so the control word is registered yet Moore-aligned.
        out_d = grostl_decode(state_d, r_d, ph_d, first_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
            final_q <= 1'b0;
            out_q   <= CTRL_OUT_IDLE;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            final_q <= final_d;
            out_q   <= out_d;
        end
    end

    assign busy      = out_q.busy;
    assign done      = out_q.done;
    assign wr_m      = out_q.wr_m;
    assign wr_h      = out_q.wr_h;
    assign sel_m     = out_q.sel_m;
    assign sel_h     = out_q.sel_h;
    assign sel_pq    = out_q.sel_pq;
    assign round     = out_q.round;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_grostl_ctrl_serial_m.sv
// Bench for the Groestl serial sequencer: per-cycle control words against a schedule
// built from the block's operation rules, plus done latency and write-enable counts.
module tb_grostl_ctrl_serial_m;
    import grostl_pkg::*;

    localparam int R = 14;
    localparam logic [11:0] IDLE_VEC = 12'b0_0_0_0_10_1_0_0000;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               first = 1'b0;
    logic               final_blk = 1'b0;
    logic               busy, done, wr_m, wr_h, sel_h, sel_pq;
    logic [1:0]         sel_m;
    logic [3:0]         round;
    grostl_ctrl_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] exp_q[$];

    grostl_ctrl_serial_m #(.ROUNDS(R)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first     (first),
        .final_blk (final_blk),
        .busy      (busy),
        .done      (done),
        .wr_m      (wr_m),
        .wr_h      (wr_h),
        .sel_m     (sel_m),
        .sel_h     (sel_h),
        .sel_pq    (sel_pq),
        .round     (round),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] obs_vec();
        return {busy, done, wr_m, wr_h, sel_m, sel_h, sel_pq, round};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected schedule: one control word per cycle from LOAD through DONE.
    task automatic build_expected(input bit f, input bit fin);
        exp_q.delete();
        exp_q.push_back({1'b1, 1'b0, 1'b1, f, 2'b00, 1'b0, 1'b0, 4'd0});
        exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 4'd0});
        for (int r = 0; r < R; r++) begin
            exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 4'(r)});
            exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 4'(r)});
        end
        if (fin) begin
            exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 4'd0});
        end else begin
            exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 4'd0});
            exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 4'd0});
            for (int r = 0; r < R; r++) begin
                exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 4'(r)});
                exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 4'(r)});
            end
            exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 4'd0});
        end
        exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 4'd0});
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_out", obs_vec(), IDLE_VEC);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; start is accepted on the next edge.
    task automatic run_block(input bit f, input bit fin, input int pulse_a,
                             input int pulse_b, input int rst_at);
        int len, done_at, n_rnd, n_wrh, n_q;
        logic [11:0] e;
        build_expected(f, fin);
        len = exp_q.size();
        done_at = -1; n_rnd = 0; n_wrh = 0; n_q = 0;
        start = 1'b1; first = f; final_blk = fin;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check("cycle_out", obs_vec(), e);
            if (done) done_at = c;
            if (wr_m && sel_m == SEL_M_ROUND) n_rnd++;
            if (wr_m && sel_m == SEL_M_ROUND && sel_pq) n_q++;
            if (wr_h) n_wrh++;
            if (c == rst_at) begin
                reset = 1'b1;
                #1;
                check("rst_now_out", obs_vec(), IDLE_VEC);
                @(posedge clk); #1;
                check("rst_edge_out", obs_vec(), IDLE_VEC);
                check("rst_state", dbg_state, ST_IDLE);
                @(negedge clk);
                reset = 1'b0;
                start = 1'b0;
                return;
            end
            start = (c == pulse_a) || (c == pulse_b);
            first = 1'($urandom);
            final_blk = 1'($urandom);
        end
        check("done_cycle", done_at, len);
        check("done_latency", len, fin ? 2 + 2 * R + 2 : 2 + 4 * R + 4);
        check("round_writes", n_rnd, fin ? R : 2 * R);
        check("q_round_writes", n_q, fin ? 0 : R);
        check("wr_h_cycles", n_wrh, (fin ? 0 : 2) + (f ? 1 : 0));
        @(negedge clk);
        check("post_done_out", obs_vec(), IDLE_VEC);
        check("post_done_state", dbg_state, ST_IDLE);
        start = 1'b0;
    endtask

    initial begin
        int len;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out", obs_vec(), IDLE_VEC);
        check("reset_state", dbg_state, ST_IDLE);
        reset = 1'b0;
        idle_cycles(5);

        run_block(1'b1, 1'b0, 10, 61, 0);
        run_block(1'b0, 1'b0, 5, 62, 0);
        run_block(1'b0, 1'b1, 3, 32, 0);
        run_block(1'b1, 1'b1, 0, 0, 0);
        idle_cycles(2);
        run_block(1'b1, 1'b0, 0, 0, 20);
        idle_cycles(1);
        run_block(1'b1, 1'b0, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            bit f, fin;
            f = 1'($urandom);
            fin = 1'($urandom);
            len = fin ? 32 : 62;
            idle_cycles($urandom_range(0, 3));
            run_block(f, fin, $urandom_range(1, len), $urandom_range(1, len),
                      (i == 5) ? $urandom_range(2, len - 1) : 0);
        end
        idle_cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
